// File: rtl/jpeg_quant_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_quant_pkg                                                           |
// | Lane geometry and the JPEG luminance quantizer / reciprocal tables.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package jpeg_quant_pkg;

  localparam int LANE_W    = 12;
  localparam int LANES     = 8;
  localparam int COL_IDX_W = 3;
  localparam int RECIP_W   = 13;
  localparam int FRAC_W    = 16;
  localparam int PROD_W    = LANE_W + RECIP_W;
  localparam int QMAG_W    = PROD_W - FRAC_W;

  localparam logic [COL_IDX_W-1:0] LAST_COL = 3'd7;

  typedef logic [RECIP_W-1:0] recip_t;
  typedef logic [6:0]         qstep_t;

  // Both tables are indexed [column][row].
  localparam qstep_t Q_TBL [LANES][LANES] = '{
    '{7'd16, 7'd12, 7'd14, 7'd14, 7'd18,  7'd24,  7'd49,  7'd72},
    '{7'd11, 7'd12, 7'd13, 7'd17, 7'd22,  7'd35,  7'd64,  7'd92},
    '{7'd10, 7'd14, 7'd16, 7'd22, 7'd37,  7'd55,  7'd78,  7'd95},
    '{7'd16, 7'd19, 7'd24, 7'd29, 7'd56,  7'd64,  7'd87,  7'd98},
    '{7'd24, 7'd26, 7'd40, 7'd51, 7'd68,  7'd81,  7'd103, 7'd112},
    '{7'd40, 7'd58, 7'd57, 7'd87, 7'd109, 7'd104, 7'd121, 7'd100},
    '{7'd51, 7'd60, 7'd69, 7'd80, 7'd103, 7'd113, 7'd120, 7'd103},
    '{7'd61, 7'd55, 7'd56, 7'd62, 7'd77,  7'd92,  7'd101, 7'd99}
  };

  // round(65536 / Q_TBL) for the same positions.
  localparam recip_t R_TBL [LANES][LANES] = '{
    '{13'd4096, 13'd5461, 13'd4681, 13'd4681, 13'd3641, 13'd2731, 13'd1337, 13'd910},
    '{13'd5958, 13'd5461, 13'd5041, 13'd3855, 13'd2979, 13'd1872, 13'd1024, 13'd712},
    '{13'd6554, 13'd4681, 13'd4096, 13'd2979, 13'd1771, 13'd1192, 13'd840,  13'd690},
    '{13'd4096, 13'd3449, 13'd2731, 13'd2260, 13'd1170, 13'd1024, 13'd753,  13'd669},
    '{13'd2731, 13'd2521, 13'd1638, 13'd1285, 13'd964,  13'd809,  13'd636,  13'd585},
    '{13'd1638, 13'd1130, 13'd1150, 13'd753,  13'd601,  13'd630,  13'd542,  13'd655},
    '{13'd1285, 13'd1092, 13'd950,  13'd819,  13'd636,  13'd580,  13'd546,  13'd636},
    '{13'd1074, 13'd1192, 13'd1170, 13'd1057, 13'd851,  13'd712,  13'd649,  13'd662}
  };

endpackage
`default_nettype wire

// File: rtl/quant_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | quant_lane                                                               |
// | One coefficient lane: S1 |c|*R product, S2 bias/shift/sign restore.      |
// | QUANT_ROUND_EN: add half an LSB before the shift (else truncate).        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module quant_lane
  import jpeg_quant_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              s1_en_i,
  input  logic              s2_en_i,
  input  logic              s1_valid_i,
  input  logic [LANE_W-1:0] coef_i,
  input  recip_t            recip_i,
  output logic [LANE_W-1:0] quant_o
);

`ifdef QUANT_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (FRAC_W - 1);
`else
  localparam logic [PROD_W-1:0] ROUND_BIAS = '0;
`endif

  logic [LANE_W-1:0] w_mag;
  logic [PROD_W-1:0] w_prod;
  logic [QMAG_W-1:0] w_qmag;
  logic [FRAC_W-1:0] w_unused_frac;
  logic [LANE_W-1:0] w_qext;
  logic [LANE_W-1:0] w_result;

  logic              sign_q,  sign_d;
  logic [PROD_W-1:0] prod_q,  prod_d;
  logic [LANE_W-1:0] quant_q, quant_d;

  // -2048 maps to 12'h800, which is the correct unsigned magnitude.
  assign w_mag    = coef_i[LANE_W-1] ? (~coef_i + 1'b1) : coef_i;
  assign w_prod   = {{RECIP_W{1'b0}}, w_mag} * {{LANE_W{1'b0}}, recip_i};

  assign {w_qmag, w_unused_frac} = prod_q + ROUND_BIAS;
  assign w_qext   = {{(LANE_W - QMAG_W){1'b0}}, w_qmag};
  assign w_result = sign_q ? (~w_qext + 1'b1) : w_qext;

  always_comb begin
    sign_d  = s1_en_i ? coef_i[LANE_W-1] : sign_q;
    prod_d  = s1_en_i ? w_prod : prod_q;
    // An empty S2 slot carries zero so the output reads 0 while idle.
    quant_d = s2_en_i ? (s1_valid_i ? w_result : '0) : quant_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sign_q  <= 1'b0;
      prod_q  <= '0;
      quant_q <= '0;
    end else begin
      sign_q  <= sign_d;
      prod_q  <= prod_d;
      quant_q <= quant_d;
    end
  end

  assign quant_o = quant_q;

endmodule
`default_nettype wire

// File: rtl/quantizer_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | quantizer_stage                                                          |
// | 8-lane JPEG column quantizer, 2-stage valid/ready pipeline.              |
// | QUANT_ROUND_EN selects round-half-away-from-zero instead of truncation.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module quantizer_stage
  import jpeg_quant_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [LANES*LANE_W-1:0] column_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [LANES*LANE_W-1:0] column_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [COL_IDX_W-1:0]    col_idx_out,
  output logic                    block_done_out
);

  logic w_s1_en;
  logic w_s2_en;
  logic w_accept;

  logic [COL_IDX_W-1:0] col_cnt_q,  col_cnt_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [COL_IDX_W-1:0] s1_idx_q,   s1_idx_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [COL_IDX_W-1:0] s2_idx_q,   s2_idx_d;
  logic                 s2_done_q,  s2_done_d;

  // A stage loads when it is empty or its content moves on this cycle.
  assign w_s2_en   = !s2_valid_q || ready_in;
  assign w_s1_en   = !s1_valid_q || w_s2_en;
  assign w_accept  = valid_in && w_s1_en;
  assign ready_out = w_s1_en;

  always_comb begin
    col_cnt_d  = w_accept ? col_cnt_q + 1'b1 : col_cnt_q;
    s1_valid_d = w_s1_en ? valid_in : s1_valid_q;
    s1_idx_d   = w_s1_en ? col_cnt_q : s1_idx_q;
    s2_valid_d = w_s2_en ? s1_valid_q : s2_valid_q;
    s2_idx_d   = w_s2_en ? (s1_valid_q ? s1_idx_q : '0) : s2_idx_q;
    s2_done_d  = w_s2_en ? (s1_valid_q && (s1_idx_q == LAST_COL)) : s2_done_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_done_q  <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_done_q  <= s2_done_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    quant_lane u_lane (
      .clk_i      (clk_in),
      .rst_n_i    (rst_n_in),
      .s1_en_i    (w_s1_en),
      .s2_en_i    (w_s2_en),
      .s1_valid_i (s1_valid_q),
      .coef_i     (column_in[g*LANE_W +: LANE_W]),
      .recip_i    (R_TBL[col_cnt_q][g]),
      .quant_o    (column_out[g*LANE_W +: LANE_W])
    );
  end

  assign valid_out      = s2_valid_q;
  assign col_idx_out    = s2_idx_q;
  assign block_done_out = s2_done_q;

endmodule
`default_nettype wire

// File: tb/tb_quantizer_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_quantizer_stage                                                       |
// | Directed and randomized checks of quantizer_stage against a golden model.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_quantizer_stage;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [95:0] column_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [95:0] column_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [2:0]  col_idx_out;
  logic        block_done_out;

  int checks = 0;
  int errors = 0;
  int outs   = 0;
  int dones  = 0;
  int accs   = 0;
  int a0;

  logic [99:0]  sb [$];
  logic [2:0]   col_model = 3'd0;
  logic         hold_prev = 1'b0;
  logic [100:0] hold_snap = '0;

  // JPEG luminance quantizer steps, [column][row].
  localparam int QB [8][8] = '{
    '{16, 12, 14, 14, 18,  24,  49,  72},
    '{11, 12, 13, 17, 22,  35,  64,  92},
    '{10, 14, 16, 22, 37,  55,  78,  95},
    '{16, 19, 24, 29, 56,  64,  87,  98},
    '{24, 26, 40, 51, 68,  81,  103, 112},
    '{40, 58, 57, 87, 109, 104, 121, 100},
    '{51, 60, 69, 80, 103, 113, 120, 103},
    '{61, 55, 56, 62, 77,  92,  101, 99}
  };

`ifdef QUANT_ROUND_EN
  localparam int BIAS = 32768;
`else
  localparam int BIAS = 0;
`endif

  quantizer_stage dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .column_in      (column_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .column_out     (column_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .col_idx_out    (col_idx_out),
    .block_done_out (block_done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [95:0] model(input logic [95:0] col, input logic [2:0] c);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int v, m, rc, q, o;
      v  = int'($signed(col[12*k +: 12]));
      m  = (v < 0) ? -v : v;
      rc = (65536 + QB[c][k] / 2) / QB[c][k];
      q  = (m * rc + BIAS) >>> 16;
      o  = (v < 0) ? -q : q;
      r[12*k +: 12] = 12'(o);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return just after the rising edge.
  task automatic cyc();
    logic acc, take;
    logic [99:0] exp_out;
    @(negedge clk_in);
    acc  = valid_in && ready_out;
    take = valid_out && ready_in;
    if (hold_prev)
      check("hold_stable", 128'({valid_out, block_done_out, col_idx_out, column_out}), 128'(hold_snap));
    hold_prev = valid_out && !ready_in;
    hold_snap = {valid_out, block_done_out, col_idx_out, column_out};
    if (take) begin
      outs++;
      if (block_done_out) dones++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=extra_output expected=none");
      end
      if (sb.size() > 0) begin
        exp_out = sb.pop_front();
        check("sb_out", 128'({block_done_out, col_idx_out, column_out}), 128'(exp_out));
      end
    end
    if (acc) begin
      accs++;
      sb.push_back({(col_model == 3'd7), col_model, model(column_in, col_model)});
      col_model = col_model + 3'd1;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    sb.delete();
    col_model = 3'd0;
    hold_prev = 1'b0;
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    logic [95:0] exp_col;

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid", 128'(valid_out), 128'(0));
    check("rst_col",   128'(column_out), 128'(0));
    check("rst_idx",   128'(col_idx_out), 128'(0));
    check("rst_done",  128'(block_done_out), 128'(0));
    check("rst_ready", 128'(ready_out), 128'(1));
    #2 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("post_rst_ready", 128'(ready_out), 128'(1));

    // First column: 160 / 16 = 10 after exactly two cycles.
    ready_in  = 1'b1;
    valid_in  = 1'b1;
    column_in = {84'd0, 12'd160};
    cyc();
    valid_in = 1'b0;
    check("lat1_valid", 128'(valid_out), 128'(0));
    cyc();
    check("lat2_valid", 128'(valid_out), 128'(1));
    check("lat2_col",   128'(column_out), 128'(96'd10));
    check("lat2_idx",   128'(col_idx_out), 128'(0));
    cyc();
    check("idle_col_zero", 128'(column_out), 128'(0));

    // Rounding/truncation vectors on column 0.
    apply_reset();
    valid_in  = 1'b1;
    column_in = {12'd1000, 12'd0, 12'd0, 12'd9, 12'd7, 12'd2047, 12'h800, 12'hFE8};
    cyc();
    valid_in = 1'b0;
    cyc();
`ifdef QUANT_ROUND_EN
    exp_col = {12'h00E, 12'h000, 12'h000, 12'h001, 12'h000, 12'h092, 12'hF55, 12'hFFE};
`else
    exp_col = {12'h00D, 12'h000, 12'h000, 12'h000, 12'h000, 12'h092, 12'hF56, 12'hFFF};
`endif
    check("neg24_lane0", 128'(column_out[11:0]), 128'(exp_col[11:0]));
    check("vec_col",     128'(column_out), 128'(exp_col));
    cyc();

    // Nine back-to-back columns: indices 0..7,0 and a single block_done.
    apply_reset();
    outs  = 0;
    dones = 0;
    valid_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      column_in = {8{12'(k * 211 - 900)}};
      cyc();
    end
    valid_in = 1'b0;
    repeat (2) cyc();
    check("b2b_outs",  128'(outs), 128'(9));
    check("b2b_dones", 128'(dones), 128'(1));
    check("b2b_last_idx", 128'(col_idx_out), 128'(0));

    // Downstream stall with continuous upstream valid.
    apply_reset();
    ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      column_in = {$urandom, $urandom, $urandom};
      cyc();
    end
    ready_in = 1'b0;
    a0 = accs;
    for (int i = 0; i < 5; i++) begin
      column_in = {$urandom, $urandom, $urandom};
      cyc();
    end
    check("stall_accepts", 128'((accs - a0) <= 2), 128'(1));
    check("stall_ready",   128'(ready_out), 128'(0));
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      column_in = {$urandom, $urandom, $urandom};
      cyc();
    end
    drain();

    // Asynchronous reset with two columns in flight.
    apply_reset();
    ready_in  = 1'b0;
    valid_in  = 1'b1;
    column_in = {8{12'd500}};
    cyc();
    column_in = {8{12'h9C4}};
    cyc();
    valid_in = 1'b0;
    check("inflight_valid", 128'(valid_out), 128'(1));
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_valid", 128'(valid_out), 128'(0));
    check("arst_col",   128'(column_out), 128'(0));
    check("arst_ready", 128'(ready_out), 128'(1));
    sb.delete();
    col_model = 3'd0;
    hold_prev = 1'b0;
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    ready_in  = 1'b1;
    valid_in  = 1'b1;
    column_in = {84'd0, 12'd160};
    cyc();
    valid_in = 1'b0;
    cyc();
    check("arst_next_idx", 128'(col_idx_out), 128'(0));
    check("arst_next_col", 128'(column_out), 128'(96'd10));
    cyc();

    // Random traffic against the reciprocal model.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      valid_in  = ($urandom % 10) < 7;
      ready_in  = ($urandom % 10) < 7;
      column_in = {$urandom, $urandom, $urandom};
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quantizer_stage.md
QUANTIZER_STAGE -- requirements
Module: quantizer_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_in  input  1  system clock, all logic on rising edge.
REQ-003 rst_n_in  input  1  asynchronous active-low reset.
REQ-004 column_in  input  96  eight signed 12-bit DCT coefficients; lane r = bits [12r+11:12r] = row r.
REQ-005 valid_in  input  1  column_in valid this cycle.
REQ-006 ready_out  output  1  block accepts a column when valid_in and ready_out are both high.
REQ-007 column_out  output  96  eight signed 12-bit quantized coefficients, same lane packing as column_in.
REQ-008 valid_out  output  1  column_out valid.
REQ-009 ready_in  input  1  downstream accepts when valid_out and ready_in are both high.
REQ-010 col_idx_out  output  3  column index (0..7) of the column on column_out.
REQ-011 block_done_out  output  1  high with valid_out when col_idx_out = 7.

Function
REQ-012 A column is accepted only on a valid_in && ready_out cycle; col_cnt (3 bits) then increments and wraps 7 -> 0.
REQ-013 Each accepted column uses Q[col_cnt][r] from the standard JPEG luminance table, indexed [column][row]; column 0 = 16,12,14,14,18,24,49,72.
REQ-014 Division SHALL use the reciprocal R[col][r] = round(65536 / Q[col][r]), an unsigned 13-bit package constant; no divider.
REQ-015 Arithmetic per lane: m = |c| (12-bit unsigned); p = m * R (25-bit); q = p >> 16 after optional rounding bias (REQ-024); out = negative of q when c < 0, else q; sign-extend to 12 bits.
REQ-016 The pipeline SHALL have two stages: S1 registers |c|, sign, and product; S2 registers the biased and shifted signed result. Latency from accept to valid_out SHALL be exactly 2 cycles with no stall.
REQ-017 Back-pressure: each stage advances when its output register is empty or being consumed; ready_out = !s1_valid || s1_advance. Throughput SHALL be one column per cycle when ready_in = 1.
REQ-018 While valid_out = 1 and ready_in = 0, column_out, col_idx_out and block_done_out SHALL hold stable.
REQ-019 col_idx_out and sign SHALL travel with the data through both stages.
REQ-020 When valid_out = 0, column_out SHALL read 0.

Reset
REQ-021 Asserting rst_n_in low at any time SHALL immediately clear col_cnt, s1_valid, s2_valid, valid_out, block_done_out, col_idx_out and column_out to 0; in-flight columns are discarded.
REQ-022 After reset, ready_out SHALL be 1.
REQ-023 After deassertion, the first accepted column SHALL use column index 0.

Configuration
REQ-024 Macro QUANT_ROUND_EN: when defined, add 32768 to p before the shift (round half away from zero on magnitude); when undefined, add nothing (truncate toward zero).

Structure
REQ-025 Package jpeg_quant_pkg SHALL hold the Q table, the R table (8x8 each), the lane width constant (12) and the lane count (8).
REQ-026 Sub-module quant_lane (one lane; S1 multiply, S2 bias/shift/sign) SHALL be instantiated 8 times; the column counter and handshake logic SHALL stay in the top module.

Verification
REQ-027 After reset, col 0, lane0 = 160, all other lanes 0, ready_in = 1 -> two cycles later: lane0 = 10, col_idx_out = 0, valid_out = 1.
REQ-028 Col 0, lane0 = -24 (R = 4096) -> lane0 = -2 with QUANT_ROUND_EN defined; -1 without it.
REQ-029 Nine back-to-back columns -> col_idx_out = 0..7, then 0; block_done_out high only on the 8th output.
REQ-030 Hold ready_in = 0 for 5 cycles with valid_in continuously high -> at most 2 columns are accepted, ready_out goes low, outputs stay stable, and no data is lost or duplicated after release.
REQ-031 Pull rst_n_in low while 2 columns are in flight -> valid_out drops at once; the next accepted column is col 0.
REQ-032 Random coefficients in [-2048, 2047] with random ready_in and valid_in -> output matches a bit-exact reciprocal golden model.
